// File: rtl/mips_mem_pkg.sv
// Shared definitions for the load/store front end: size codes, FSM states
// and the byte-lane extract/merge helpers used by both the memory access
// unit and the lane alignment block.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    MERGE  = 2'b10,
    RESP   = 2'b11
  } state_t;

  // Pull the addressed lane out of a little-endian word and extend it.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  size,
                                               input logic        sext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = {{24{sext & b[7]}}, b};
      SZ_HALF: r = {{16{sext & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed lane(s) of the old word with right-justified data.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  lane,
                                             input logic [1:0]  size);
    logic [31:0] r;
    r = old_word;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0:    r[7:0]   = wdata[7:0];
          2'd1:    r[15:8]  = wdata[7:0];
          2'd2:    r[23:16] = wdata[7:0];
          default: r[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) r[31:16] = wdata[15:0];
        else         r[15:0]  = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane alignment: load extract/extend path and sub-word
// store merge path. Shared with the future cache datapath.
import mips_mem_pkg::*;

module mem_lane_align (
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] load_val,
  output logic [31:0] merge_word
);

  assign load_val   = lane_extract(rd_word, lane, size, sign_ext);
  assign merge_word = lane_merge(rd_word, wdata, lane, size);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for the word-addressed data memory. Converts byte
// addresses to word indices, does read-modify-write for sub-word stores,
// extends sub-word loads and rejects faulting requests without a write.
import mips_mem_pkg::*;

module mem_access_unit #(
  parameter int DEPTH = 100,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [1:0]    size,
  input  logic          sign_ext,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          ready,
  output logic          done,
  output logic          err,
  output logic [31:0]   rdata,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wd,
  output logic          mem_we,
  input  logic [31:0]   mem_rd
);

  state_t        state_r, state_s;
  logic          we_r;
  logic [1:0]    size_r;
  logic          sext_r;
  logic [1:0]    lane_r;
  logic [31:0]   wdata_r;
  logic          done_r;
  logic          err_r;
  logic [31:0]   rdata_r;
  logic [31:0]   mem_addr_r;
  logic [31:0]   mem_wd_r;
  logic          mem_we_r;
  logic [AW-1:0] widx_s;
  logic          fault_s;
  logic          accept_s;
  logic          subword_s;
  logic [31:0]   load_val_s;
  logic [31:0]   merge_s;

  assign widx_s   = addr >> 2;
  assign fault_s  = (size == 2'b11) ||
                    ((size == SZ_HALF) && addr[0]) ||
                    ((size == SZ_WORD) && (addr[1:0] != 2'b00)) ||
                    (widx_s >= AW'(DEPTH));
  assign accept_s  = (state_r == IDLE) && req;
  assign subword_s = (size_r != SZ_WORD);

  mem_lane_align u_align (
    .rd_word    (mem_rd),
    .wdata      (wdata_r),
    .lane       (lane_r),
    .size       (size_r),
    .sign_ext   (sext_r),
    .load_val   (load_val_s),
    .merge_word (merge_s)
  );

  // Next-state decode for the access sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req) state_s = fault_s ? RESP : ACCESS;
        else     state_s = IDLE;
      end
      ACCESS: begin
        if (we_r && subword_s) state_s = MERGE;
        else                   state_s = RESP;
      end
      MERGE:   state_s = RESP;
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, request latch and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      we_r       <= 1'b0;
      size_r     <= SZ_BYTE;
      sext_r     <= 1'b0;
      lane_r     <= 2'b00;
      wdata_r    <= 32'h0000_0000;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      rdata_r    <= 32'h0000_0000;
      mem_addr_r <= 32'h0000_0000;
      mem_wd_r   <= 32'h0000_0000;
      mem_we_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      done_r   <= (state_s == RESP);
      err_r    <= accept_s && fault_s;
      // Word store writes in ACCESS; sub-word store writes in MERGE.
      mem_we_r <= (accept_s && !fault_s && we && (size == SZ_WORD)) ||
                  ((state_r == ACCESS) && we_r && subword_s);
      if (accept_s) begin
        we_r       <= we;
        size_r     <= size;
        sext_r     <= sign_ext;
        lane_r     <= addr[1:0];
        wdata_r    <= wdata;
        mem_addr_r <= 32'(widx_s);
        mem_wd_r   <= wdata;
      end else if (state_r == ACCESS) begin
        if (!we_r)          rdata_r  <= load_val_s;
        else if (subword_s) mem_wd_r <= merge_s;
      end
    end
  end

  assign ready    = (state_r == IDLE);
  assign done     = done_r;
  assign err      = err_r;
  assign rdata    = rdata_r;
  assign mem_addr = mem_addr_r;
  assign mem_wd   = mem_wd_r;
  // A reset arriving in the write cycle must suppress that write.
  assign mem_we   = mem_we_r && !rst;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 100-word memory model.
module tb_mem_access_unit;

  localparam logic [1:0] B = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] W = 2'b10;

  logic        clk = 1'b0;
  logic        rst, req, we, sign_ext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        ready, done, err, mem_we;
  logic [31:0] rdata, mem_addr, mem_wd, mem_rd;

  logic [31:0] mem [0:99];
  logic        pre_en = 1'b0;
  logic [6:0]  pre_idx = 7'd0;
  logic [31:0] pre_val = 32'h0;
  int          cyc = 0;
  int          we_cnt = 0;
  logic [31:0] last_wa = 32'h0, last_wd = 32'h0;

  int          n_checks = 0;
  int          n_fail = 0;
  int          r_lat, r_wes;
  logic        r_err;
  logic [31:0] r_rdata;

  mem_access_unit #(.DEPTH(100), .AW(32)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .ready(ready),
    .done(done), .err(err), .rdata(rdata), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = (mem_addr < 32'd100) ? mem[mem_addr[6:0]] : 32'h0;

  // Memory model, write counter and cycle counter.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      we_cnt  <= we_cnt + 1;
      last_wa <= mem_addr;
      last_wd <= mem_wd;
      if (mem_addr < 32'd100) mem[mem_addr[6:0]] <= mem_wd;
    end else if (pre_en) begin
      mem[pre_idx] <= pre_val;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preset(input int idx, input logic [31:0] val);
    @(negedge clk);
    pre_idx = 7'(idx);
    pre_val = val;
    pre_en  = 1'b1;
    @(negedge clk);
    pre_en  = 1'b0;
  endtask

  // Issue one request and wait for its done; fills r_* results.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] d);
    int acc, we0;
    bit seen;
    @(negedge clk);
    we0 = we_cnt;
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
    acc = cyc;
    @(posedge clk);
    #1 req = 1'b0;
    seen = 1'b0;
    r_lat = 99;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen    = 1'b1;
        r_lat   = cyc - acc;
        r_err   = err;
        r_rdata = rdata;
      end
    end
    if (!seen) check_val("done_timeout", 32'd0, 32'd1);
    r_wes = we_cnt - we0;
  endtask

  initial begin : main
    int acc1, d1, d2, dones, we0;
    rst = 1'b1; req = 1'b0; we = 1'b0; size = W; sign_ext = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rst_ready", 32'(ready), 32'd1);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_rdata", rdata, 32'h0);
    check_val("rst_mem_we", 32'(mem_we), 32'd0);
    check_val("rst_mem_addr", mem_addr, 32'h0);
    check_val("rst_mem_wd", mem_wd, 32'h0);

    // Word store then load
    do_req(1'b1, W, 1'b0, 32'h8, 32'hDEADBEEF);
    check_val("sw_lat", 32'(r_lat), 32'd2);
    check_val("sw_err", 32'(r_err), 32'd0);
    check_val("sw_wes", 32'(r_wes), 32'd1);
    check_val("sw_wa", last_wa, 32'd2);
    check_val("sw_wd", last_wd, 32'hDEADBEEF);
    do_req(1'b0, W, 1'b0, 32'h8, 32'h0);
    check_val("lw_lat", 32'(r_lat), 32'd2);
    check_val("lw_err", 32'(r_err), 32'd0);
    check_val("lw_rdata", r_rdata, 32'hDEADBEEF);
    check_val("lw_wes", 32'(r_wes), 32'd0);

    // Sub-word store merge
    preset(2, 32'h11223344);
    do_req(1'b1, B, 1'b0, 32'h9, 32'h123456AB);
    check_val("sb_lat", 32'(r_lat), 32'd3);
    check_val("sb_wes", 32'(r_wes), 32'd1);
    check_val("sb_wd", last_wd, 32'h1122AB44);
    check_val("sb_mem", mem[2], 32'h1122AB44);
    do_req(1'b1, H, 1'b0, 32'hA, 32'hFFFFCAFE);
    check_val("sh_lat", 32'(r_lat), 32'd3);
    check_val("sh_wes", 32'(r_wes), 32'd1);
    check_val("sh_wd", last_wd, 32'hCAFEAB44);

    // Load extension
    preset(2, 32'h80FF7F01);
    do_req(1'b0, B, 1'b1, 32'hA, 32'h0);
    check_val("lb_a", r_rdata, 32'hFFFFFFFF);
    check_val("lb_lat", 32'(r_lat), 32'd2);
    do_req(1'b0, B, 1'b0, 32'hA, 32'h0);
    check_val("lbu_a", r_rdata, 32'h000000FF);
    do_req(1'b0, B, 1'b1, 32'h9, 32'h0);
    check_val("lb_9", r_rdata, 32'h0000007F);
    do_req(1'b0, H, 1'b1, 32'hA, 32'h0);
    check_val("lh_a", r_rdata, 32'hFFFF80FF);
    do_req(1'b0, H, 1'b0, 32'h8, 32'h0);
    check_val("lhu_8", r_rdata, 32'h00007F01);
    check_val("ld_wes", 32'(r_wes), 32'd0);

    // Faults: one cycle latency, err, no write, rdata held
    do_req(1'b0, W, 1'b0, 32'h6, 32'h0);
    check_val("f_lw6_lat", 32'(r_lat), 32'd1);
    check_val("f_lw6_err", 32'(r_err), 32'd1);
    check_val("f_lw6_rdata", r_rdata, 32'h00007F01);
    do_req(1'b1, H, 1'b0, 32'h3, 32'h1234);
    check_val("f_sh3_err", 32'(r_err), 32'd1);
    check_val("f_sh3_lat", 32'(r_lat), 32'd1);
    check_val("f_sh3_wes", 32'(r_wes), 32'd0);
    do_req(1'b1, 2'b11, 1'b0, 32'h0, 32'h1234);
    check_val("f_sz_err", 32'(r_err), 32'd1);
    check_val("f_sz_wes", 32'(r_wes), 32'd0);
    do_req(1'b1, W, 1'b0, 32'h190, 32'h5555AAAA);
    check_val("f_oor_err", 32'(r_err), 32'd1);
    check_val("f_oor_lat", 32'(r_lat), 32'd1);
    check_val("f_oor_wes", 32'(r_wes), 32'd0);
    check_val("f_oor_rdata", r_rdata, 32'h00007F01);
    // Last legal word index
    do_req(1'b1, W, 1'b0, 32'h18C, 32'h12345678);
    check_val("top_err", 32'(r_err), 32'd0);
    check_val("top_wa", last_wa, 32'd99);
    check_val("top_rdata", r_rdata, 32'h00007F01);

    // Back-to-back with held req
    @(negedge clk);
    check_val("b2b_ready", 32'(ready), 32'd1);
    req = 1'b1; we = 1'b0; size = W; sign_ext = 1'b0; addr = 32'h8;
    acc1 = cyc; dones = 0; d1 = 0; d2 = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        if (dones == 1) begin
          d1 = cyc;
          check_val("b2b_rd1", rdata, 32'h80FF7F01);
          size = B; addr = 32'hB;
        end else begin
          d2 = cyc;
          check_val("b2b_rd2", rdata, 32'h00000080);
          req = 1'b0;
        end
      end
    end
    req = 1'b0;
    check_val("b2b_dones", 32'(dones), 32'd2);
    check_val("b2b_lat1", 32'(d1 - acc1), 32'd2);
    check_val("b2b_gap", 32'(d2 - d1), 32'd3);

    // req toggled while busy
    @(negedge clk);
    we0 = we_cnt;
    req = 1'b1; we = 1'b1; size = W; addr = 32'h10; wdata = 32'hA5A5A5A5;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        req = 1'b0;
      end else if (dones == 0) begin
        req = ~req;
      end
    end
    req = 1'b0;
    check_val("tog_dones", 32'(dones), 32'd1);
    check_val("tog_wes", 32'(we_cnt - we0), 32'd1);

    // Reset during MERGE
    preset(5, 32'h55667788);
    we0 = we_cnt;
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = B; sign_ext = 1'b0; addr = 32'h14; wdata = 32'h99;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 check_val("rmid_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rmid_ready", 32'(ready), 32'd1);
    check_val("rmid_done", 32'(done), 32'd0);
    check_val("rmid_err", 32'(err), 32'd0);
    check_val("rmid_rdata", rdata, 32'h0);
    check_val("rmid_maddr", mem_addr, 32'h0);
    check_val("rmid_mwd", mem_wd, 32'h0);
    repeat (4) @(negedge clk);
    check_val("rmid_mem", mem[5], 32'h55667788);
    check_val("rmid_wes", 32'(we_cnt - we0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
